// File: rtl/processor_pkg.sv
// Shared processor definitions used by the fetch/decode boundary and the decoder.
//   OPCODE_MSB/OPCODE_LSB : position of the 5-bit opcode field in a 16-bit word
//   DEFAULT_NOP_WORD      : word presented to decode when nothing is valid
//   DEFAULT_IMM_MASK      : bit i set => opcode i is followed by an immediate word
//   if_id_state_e         : instruction-assembly state of the IF/ID register
//   is_imm_opcode()       : tells whether a word's opcode takes an immediate
package processor_pkg;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;

  localparam logic [15:0] DEFAULT_NOP_WORD = 16'h0000;
  localparam logic [31:0] DEFAULT_IMM_MASK = 32'h0000_0080;

  typedef enum logic {
    EXPECT_OP = 1'b0,
    WAIT_IMM  = 1'b1
  } if_id_state_e;

  function automatic logic is_imm_opcode(input logic [31:0] mask, input logic [15:0] word);
    return mask[word[OPCODE_MSB:OPCODE_LSB]];
  endfunction

endpackage

// File: rtl/if_id_stage.sv
// IF/ID pipeline register. Pairs opcodes that need an immediate with the
// following fetch word and presents decode one complete instruction.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   stall             : hold every register, consume no input
//   flush             : drop in-flight/half-assembled contents (beats stall)
//   in_valid/in_word  : fetch word and its valid
//   in_pc/in_next_pc  : address of in_word and the address after it
//   out_valid, out_instruction, out_immediate, out_has_imm,
//   out_pc, out_next_pc : registered instruction bundle to decode
//   imm_pending       : an opcode is waiting for its immediate word
module if_id_stage
  import processor_pkg::*;
#(
  parameter logic [31:0] IMM_MASK = DEFAULT_IMM_MASK,
  parameter logic [15:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [15:0] in_word,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_next_pc,
  output logic        out_valid,
  output logic [15:0] out_instruction,
  output logic [15:0] out_immediate,
  output logic        out_has_imm,
  output logic [31:0] out_pc,
  output logic [31:0] out_next_pc,
  output logic        imm_pending
);

  if_id_state_e state_q, state_d;
  logic [15:0]  held_word_q, held_word_d;
  logic [31:0]  held_pc_q, held_pc_d;
  logic         out_valid_q, out_valid_d;
  logic [15:0]  out_instruction_q, out_instruction_d;
  logic [15:0]  out_immediate_q, out_immediate_d;
  logic         out_has_imm_q, out_has_imm_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_next_pc_q, out_next_pc_d;

  always_comb begin
    state_d           = state_q;
    held_word_d       = held_word_q;
    held_pc_d         = held_pc_q;
    out_valid_d       = out_valid_q;
    out_instruction_d = out_instruction_q;
    out_immediate_d   = out_immediate_q;
    out_has_imm_d     = out_has_imm_q;
    out_pc_d          = out_pc_q;
    out_next_pc_d     = out_next_pc_q;

    if (flush) begin
      state_d           = EXPECT_OP;
      held_word_d       = '0;
      held_pc_d         = '0;
      out_valid_d       = 1'b0;
      out_instruction_d = NOP_WORD;
      out_immediate_d   = '0;
      out_has_imm_d     = 1'b0;
      out_pc_d          = '0;
      out_next_pc_d     = '0;
    end else if (!stall) begin
      // Bubble unless one of the emit paths below fires.
      out_valid_d       = 1'b0;
      out_instruction_d = NOP_WORD;
      unique case (state_q)
        EXPECT_OP: begin
          if (in_valid) begin
            if (is_imm_opcode(IMM_MASK, in_word)) begin
              state_d     = WAIT_IMM;
              held_word_d = in_word;
              held_pc_d   = in_pc;
            end else begin
              out_valid_d       = 1'b1;
              out_instruction_d = in_word;
              out_immediate_d   = '0;
              out_has_imm_d     = 1'b0;
              out_pc_d          = in_pc;
              out_next_pc_d     = in_next_pc;
            end
          end
        end
        WAIT_IMM: begin
          // The word here is data, never opcode-decoded.
          if (in_valid) begin
            state_d           = EXPECT_OP;
            out_valid_d       = 1'b1;
            out_instruction_d = held_word_q;
            out_immediate_d   = in_word;
            out_has_imm_d     = 1'b1;
            out_pc_d          = held_pc_q;
            out_next_pc_d     = in_next_pc;
          end
        end
        default: state_d = EXPECT_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= EXPECT_OP;
      held_word_q       <= '0;
      held_pc_q         <= '0;
      out_valid_q       <= 1'b0;
      out_instruction_q <= NOP_WORD;
      out_immediate_q   <= '0;
      out_has_imm_q     <= 1'b0;
      out_pc_q          <= '0;
      out_next_pc_q     <= '0;
    end else begin
      state_q           <= state_d;
      held_word_q       <= held_word_d;
      held_pc_q         <= held_pc_d;
      out_valid_q       <= out_valid_d;
      out_instruction_q <= out_instruction_d;
      out_immediate_q   <= out_immediate_d;
      out_has_imm_q     <= out_has_imm_d;
      out_pc_q          <= out_pc_d;
      out_next_pc_q     <= out_next_pc_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_instruction = out_instruction_q;
  assign out_immediate   = out_immediate_q;
  assign out_has_imm     = out_has_imm_q;
  assign out_pc          = out_pc_q;
  assign out_next_pc     = out_next_pc_q;
  assign imm_pending     = (state_q == WAIT_IMM);

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;
  import processor_pkg::*;

  localparam logic [31:0] MASK = 32'h0000_0080;
  localparam logic [15:0] NOP  = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_word = '0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_next_pc = '0;
  logic        out_valid;
  logic [15:0] out_instruction;
  logic [15:0] out_immediate;
  logic        out_has_imm;
  logic [31:0] out_pc;
  logic [31:0] out_next_pc;
  logic        imm_pending;

  if_id_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_word(in_word), .in_pc(in_pc), .in_next_pc(in_next_pc),
    .out_valid(out_valid), .out_instruction(out_instruction), .out_immediate(out_immediate),
    .out_has_imm(out_has_imm), .out_pc(out_pc), .out_next_pc(out_next_pc),
    .imm_pending(imm_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic        has_imm;
    logic [31:0] pc;
    logic [31:0] npc;
  } txn_t;

  typedef struct packed {
    logic valid;
    logic pend;
  } stat_t;

  txn_t  txn_q[$];
  stat_t stat_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an instruction is an opcode word optionally followed by
  // one immediate word; a pending opcode waits for the next accepted word.
  bit          m_pend = 0;
  logic [15:0] m_word = '0;
  logic [31:0] m_pc = '0;
  bit          m_valid = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit f, input bit v,
                      input logic [15:0] w, input logic [31:0] pc, input logic [31:0] npc);
    txn_t t;
    @(negedge clk);
    rst = r; stall = s; flush = f; in_valid = v;
    in_word = w; in_pc = pc; in_next_pc = npc;
    if (r || f) begin
      m_pend = 0; m_valid = 0;
    end else if (s) begin
      // nothing moves
    end else if (v && m_pend) begin
      t = '{instr: m_word, imm: w, has_imm: 1'b1, pc: m_pc, npc: npc};
      txn_q.push_back(t);
      m_pend = 0; m_valid = 1;
    end else if (v && MASK[w[15:11]]) begin
      m_pend = 1; m_word = w; m_pc = pc; m_valid = 0;
    end else if (v) begin
      t = '{instr: w, imm: 16'h0, has_imm: 1'b0, pc: pc, npc: npc};
      txn_q.push_back(t);
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    stat_q.push_back('{valid: m_valid, pend: m_pend});
    $display("drive rst=%0b stall=%0b flush=%0b valid=%0b word=%h pc=%h npc=%h",
             r, s, f, v, w, pc, npc);
  endtask

  // Monitor: one expected status per edge; a fresh valid output consumes one
  // scoreboard entry, a held (stalled) output must repeat the previous one.
  txn_t last_t = '0;
  initial begin
    stat_t st;
    txn_t  t;
    forever begin
      @(posedge clk); #1;
      if (stat_q.size() > 0) begin
        st = stat_q.pop_front();
        chk("out_valid", {31'b0, out_valid}, {31'b0, st.valid});
        chk("imm_pending", {31'b0, imm_pending}, {31'b0, st.pend});
        if (!out_valid) begin
          chk("nop_word", {16'b0, out_instruction}, {16'b0, NOP});
        end else begin
          if (stall && !flush && !rst) begin
            t = last_t;
          end else if (txn_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_output: got instr %h expected none", out_instruction);
            t = '{instr: out_instruction, imm: out_immediate, has_imm: out_has_imm,
                  pc: out_pc, npc: out_next_pc};
          end else begin
            t = txn_q.pop_front();
          end
          last_t = t;
          chk("instr", {16'b0, out_instruction}, {16'b0, t.instr});
          chk("imm", {16'b0, out_immediate}, {16'b0, t.imm});
          chk("has_imm", {31'b0, out_has_imm}, {31'b0, t.has_imm});
          chk("pc", out_pc, t.pc);
          chk("next_pc", out_next_pc, t.npc);
          $display("out instr=%h imm=%h has_imm=%0b pc=%h npc=%h",
                   out_instruction, out_immediate, out_has_imm, out_pc, out_next_pc);
        end
      end
    end
  end

  initial begin
    logic [31:0] pc;
    logic [15:0] w;
    bit s, f, v;

    // Reset held with a valid immediate opcode on the input.
    step(1, 0, 0, 1, 16'h3811, 32'h0, 32'h1);
    step(1, 0, 0, 1, 16'h3811, 32'h0, 32'h1);
    @(posedge clk); #2;
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_next_pc", out_next_pc, 32'h0);
    chk("rst_has_imm", {31'b0, out_has_imm}, 32'h0);
    chk("rst_imm", {16'b0, out_immediate}, 32'h0);
    chk("rst_instr", {16'b0, out_instruction}, 32'h0);

    // Plain instruction.
    step(0, 0, 0, 1, 16'h0804, 32'h10, 32'h11);
    step(0, 0, 0, 0, 16'h0, 32'h0, 32'h0);
    // Immediate pairing.
    step(0, 0, 0, 1, 16'h3811, 32'h0, 32'h1);
    step(0, 0, 0, 1, 16'h0004, 32'h1, 32'h2);
    // Stall in WAIT_IMM with garbage on the input.
    step(0, 0, 0, 1, 16'h3811, 32'h0, 32'h1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 16'hFFFF, 32'h1, 32'h2);
    step(0, 0, 0, 1, 16'h0004, 32'h1, 32'h2);
    // Immediate word whose bits look like an immediate opcode.
    step(0, 0, 0, 1, 16'h3811, 32'h20, 32'h21);
    step(0, 0, 0, 1, 16'h3AAA, 32'h21, 32'h22);
    // Flush mid-pair, then a plain instruction.
    step(0, 0, 0, 1, 16'h3811, 32'h0, 32'h1);
    step(0, 0, 1, 1, 16'h1234, 32'h1, 32'h2);
    @(posedge clk); #2;
    chk("flush_out_pc", out_pc, 32'h0);
    chk("flush_has_imm", {31'b0, out_has_imm}, 32'h0);
    step(0, 0, 0, 1, 16'h0804, 32'h40, 32'h41);
    // Valid output held by stall, then flush+stall together.
    step(0, 1, 0, 1, 16'h0805, 32'h41, 32'h42);
    step(0, 1, 1, 1, 16'h0805, 32'h41, 32'h42);
    step(0, 0, 0, 0, 16'h0, 32'h0, 32'h0);

    // Randomized traffic.
    pc = 32'h100;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(99) < 20);
      f = ($urandom_range(99) < 5);
      v = ($urandom_range(99) < 75);
      w = 16'($urandom());
      if ($urandom_range(3) == 0) w[15:11] = 5'b00111;
      step(0, s, f, v, w, pc, pc + 32'h1);
      if (f) pc = {$urandom_range(32'hFFFF), 4'h0};
      else if (v && !s) pc = pc + 32'h1;
    end
    step(0, 0, 0, 0, 16'h0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 16'h0, 32'h0, 32'h0);
    @(posedge clk); #3;
    chk("scoreboard_drained", txn_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
